pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 98 +++++++++
 tb/tb_pipe_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/exception controller: per-stage stall vector, one-cycle flush with
// PC redirect, a saturating stalled-cycle counter and a sticky consecutive-stall watchdog.
module pipe_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
    parameter int unsigned WDOG_LIMIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc_i,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic [31:0] stall_cnt,
    output logic        stall_timeout
);

    localparam logic [31:0] ExcEret = 32'h0000_000e;

    typedef enum logic {
        StRun,
        StFlush
    } state_e;

    state_e     state_q;
    logic [7:0] run_len_q;
    logic       enter_flush;
    logic [8:0] run_len_inc;
    logic       wdog_hit;

    // A stall request holds its own stage and everything upstream of it.
    always_comb begin
        stall = 6'b000000;
        if (!rst && state_q == StRun) begin
            if (stallreq_mem) begin
                stall = 6'b011111;
            end else if (stallreq_ex) begin
                stall = 6'b001111;
            end else if (stallreq_id) begin
                stall = 6'b000111;
            end
        end
    end

    always_comb begin
        enter_flush = (state_q == StRun) && (excepttype_i != 32'h0);
        run_len_inc = {1'b0, run_len_q} + 9'd1;
        wdog_hit    = stall[0] && ({23'h0, run_len_inc} == WDOG_LIMIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StRun;
            flush         <= 1'b0;
            new_pc        <= 32'h0;
            stall_cnt     <= 32'h0;
            run_len_q     <= 8'h0;
            stall_timeout <= 1'b0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (enter_flush) begin
                        state_q <= StFlush;
                        flush   <= 1'b1;
                        new_pc  <= (excepttype_i == ExcEret) ? cp0_epc_i : EXC_VECTOR;
                    end
                end
                StFlush: begin
                    state_q <= StRun;
                    flush   <= 1'b0;
                end
                default: begin
                    state_q <= StRun;
                    flush   <= 1'b0;
                end
            endcase

            if (stall[0] && stall_cnt != 32'hFFFF_FFFF) begin
                stall_cnt <= stall_cnt + 32'd1;
            end

            // The run of consecutive stalls ends on any unstalled edge or a flush.
            if (!stall[0] || enter_flush) begin
                run_len_q <= 8'h0;
            end else if (run_len_q != 8'hFF) begin
                run_len_q <= run_len_inc[7:0];
            end

            if (wdog_hit) begin
                stall_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl: stall priority, flush/redirect, watchdog, reset.
module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic [31:0] excepttype_i;
    logic [31:0] cp0_epc_i;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic [31:0] stall_cnt;
    logic        stall_timeout;

    int errors = 0;
    int checks = 0;

    pipe_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .stallreq_mem (stallreq_mem),
        .excepttype_i (excepttype_i),
        .cp0_epc_i    (cp0_epc_i),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .stall_cnt    (stall_cnt),
        .stall_timeout(stall_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance past one rising edge; inputs changed afterwards settle before the next edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst          = 1'b1;
        stallreq_id  = 1'b0;
        stallreq_ex  = 1'b0;
        stallreq_mem = 1'b1;
        excepttype_i = 32'h0;
        cp0_epc_i    = 32'h0;
        tick();
        tick();
        check("rst_stall", {26'h0, stall}, 32'h0);
        check("rst_flush", {31'h0, flush}, 32'h0);
        check("rst_new_pc", new_pc, 32'h0);
        check("rst_stall_cnt", stall_cnt, 32'h0);
        check("rst_timeout", {31'h0, stall_timeout}, 32'h0);
        stallreq_mem = 1'b0;
        rst          = 1'b0;
        tick();

        // ID stall for three cycles.
        stallreq_id = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("id_stall", {26'h0, stall}, 32'h07);
            check("id_no_flush", {31'h0, flush}, 32'h0);
            tick();
        end
        stallreq_id = 1'b0;
        settle();
        check("id_release", {26'h0, stall}, 32'h0);
        check("id_stall_cnt", stall_cnt, 32'd3);

        // Priority: MEM over EX over ID.
        stallreq_id  = 1'b1;
        stallreq_ex  = 1'b1;
        stallreq_mem = 1'b1;
        settle();
        check("prio_mem", {26'h0, stall}, 32'h1F);
        stallreq_mem = 1'b0;
        settle();
        check("prio_ex", {26'h0, stall}, 32'h0F);
        stallreq_ex = 1'b0;
        stallreq_id = 1'b0;
        settle();

        // Ordinary exception goes to the exception vector.
        excepttype_i = 32'h8;
        settle();
        check("exc_pre_flush", {31'h0, flush}, 32'h0);
        tick();
        stallreq_id = 1'b1;  // ignored while flushing
        settle();
        check("exc_flush", {31'h0, flush}, 32'h1);
        check("exc_new_pc", new_pc, 32'h20);
        check("exc_stall", {26'h0, stall}, 32'h0);
        tick();
        excepttype_i = 32'h0;
        stallreq_id  = 1'b0;
        settle();
        check("exc_flush_end", {31'h0, flush}, 32'h0);
        check("exc_new_pc_hold", new_pc, 32'h20);
        check("exc_stall_cnt", stall_cnt, 32'd3);

        // ERET with a concurrent MEM stall redirects to EPC.
        cp0_epc_i    = 32'hBFC0_0100;
        excepttype_i = 32'he;
        stallreq_mem = 1'b1;
        settle();
        check("eret_same_stall", {26'h0, stall}, 32'h1F);
        tick();
        excepttype_i = 32'h0;
        settle();
        check("eret_flush", {31'h0, flush}, 32'h1);
        check("eret_new_pc", new_pc, 32'hBFC0_0100);
        check("eret_stall", {26'h0, stall}, 32'h0);
        tick();
        stallreq_mem = 1'b0;
        settle();
        check("eret_flush_end", {31'h0, flush}, 32'h0);
        check("eret_stall_cnt", stall_cnt, 32'd4);

        // Reset in the middle of a flush.
        excepttype_i = 32'h8;
        tick();
        excepttype_i = 32'h0;
        settle();
        check("rflush_flush", {31'h0, flush}, 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        check("rflush_flush_clr", {31'h0, flush}, 32'h0);
        check("rflush_new_pc", new_pc, 32'h0);
        check("rflush_stall_cnt", stall_cnt, 32'h0);

        // Watchdog: long EX stall.
        stallreq_ex = 1'b1;
        for (int i = 0; i < 254; i++) tick();
        check("wdog_254", {31'h0, stall_timeout}, 32'h0);
        tick();
        check("wdog_255", {31'h0, stall_timeout}, 32'h1);
        for (int i = 0; i < 45; i++) tick();
        stallreq_ex = 1'b0;
        tick();
        check("wdog_sticky", {31'h0, stall_timeout}, 32'h1);
        check("wdog_stall_cnt", stall_cnt, 32'd300);
        excepttype_i = 32'h8;
        tick();
        excepttype_i = 32'h0;
        tick();
        check("wdog_flush_keep", {31'h0, stall_timeout}, 32'h1);
        check("wdog_flush_cnt", stall_cnt, 32'd300);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        check("wdog_rst", {31'h0, stall_timeout}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
